// File: rtl/object_scheduler.sv
// Per-frame object scheduler: scrolls, animates and spawns the display object slots on each vsync fall.
// Optional build macro OBJ_WRAP_EN: objects leaving the left edge re-enter on the right instead of despawning.
module object_scheduler #(
    parameter int NUM_OBJ      = 5,
    parameter int ANIM_DIV_LOG = 3,
    parameter int SCREEN_WIDTH = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync,
    input  logic [10:0] d_offset,
    input  logic        spawn_req,
    input  logic [1:0]  spawn_type,
    input  logic [9:0]  spawn_vpos,
    output logic        spawn_ack,
    output logic        spawn_drop,
    output logic [25:0] obj1,
    output logic [25:0] obj2,
    output logic [25:0] obj3,
    output logic [25:0] obj4,
    output logic [25:0] obj5,
    output logic [4:0]  active,
    output logic        busy
);

    localparam int          SLOT_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [10:0] SPAWN_HPOS = 11'(SCREEN_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_SPAWN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [SLOT_W-1:0]       slot_reg;
    logic                    prev_vsync_reg;
    logic                    frame_evt;
    logic [ANIM_DIV_LOG-1:0] anim_cnt_reg;
    logic                    anim_step_reg;
    logic [10:0]             d_off_reg;

    logic [25:0]             obj_reg [NUM_OBJ];
    logic [NUM_OBJ-1:0]      active_reg;
    logic [25:0]             shadow_reg [NUM_OBJ];
    logic [NUM_OBJ-1:0]      shadow_active_reg;

    logic                    pending_reg;
    logic [1:0]              pend_type_reg;
    logic [9:0]              pend_vpos_reg;

    logic                    free_found;
    logic [SLOT_W-1:0]       free_slot;
    logic [25:0]             upd_desc   [NUM_OBJ];
    logic                    upd_active [NUM_OBJ];

    assign frame_evt = prev_vsync_reg & ~vsync;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (frame_evt) state_next = ST_UPDATE;
            ST_UPDATE: if (slot_reg == SLOT_W'(NUM_OBJ - 1)) state_next = ST_SPAWN;
            ST_SPAWN:  state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        spawn_ack  = 1'b0;
        spawn_drop = 1'b0;
        if (state_reg != ST_IDLE) begin
            busy = 1'b1;
        end
        if (state_reg == ST_SPAWN && pending_reg) begin
            spawn_ack  = free_found;
            spawn_drop = ~free_found;
        end
    end

    // Lowest-index slot still free after this frame's scroll pass
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (!shadow_active_reg[i]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
        end
    end

    // Scrolled/animated value for each slot; only the slot being visited is written back
    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_slot
            logic [2:0]  cur_frame;
            logic [1:0]  cur_type;
            logic [10:0] cur_hpos;
            logic [9:0]  cur_vpos;
            logic [2:0]  nxt_frame;
            logic        underflow;
            logic [25:0] moved_desc;
            logic [25:0] under_desc;
            logic        under_active;

            assign cur_frame  = shadow_reg[gi][25:23];
            assign cur_type   = shadow_reg[gi][22:21];
            assign cur_hpos   = shadow_reg[gi][20:10];
            assign cur_vpos   = shadow_reg[gi][9:0];
            assign nxt_frame  = cur_frame + {2'b00, anim_step_reg};
            assign underflow  = cur_hpos < d_off_reg;
            assign moved_desc = {nxt_frame, cur_type, cur_hpos - d_off_reg, cur_vpos};
`ifdef OBJ_WRAP_EN
            assign under_desc   = {nxt_frame, cur_type,
                                   SPAWN_HPOS - (d_off_reg - cur_hpos - 11'd1), cur_vpos};
            assign under_active = 1'b1;
`else
            assign under_desc   = '0;
            assign under_active = 1'b0;
`endif
            assign upd_desc[gi]   = !shadow_active_reg[gi] ? shadow_reg[gi]
                                  : (underflow ? under_desc : moved_desc);
            assign upd_active[gi] = shadow_active_reg[gi] & (~underflow | under_active);
        end
    endgenerate

    // ---------------- Datapath ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_vsync_reg    <= 1'b0;
            slot_reg          <= '0;
            anim_cnt_reg      <= '0;
            anim_step_reg     <= 1'b0;
            d_off_reg         <= '0;
            pending_reg       <= 1'b0;
            pend_type_reg     <= '0;
            pend_vpos_reg     <= '0;
            active_reg        <= '0;
            shadow_active_reg <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                obj_reg[i]    <= '0;
                shadow_reg[i] <= '0;
            end
        end else begin
            prev_vsync_reg <= vsync;
            slot_reg       <= (state_reg == ST_UPDATE) ? slot_reg + SLOT_W'(1) : '0;

            if (state_reg == ST_IDLE && frame_evt) begin
                anim_cnt_reg  <= anim_cnt_reg + ANIM_DIV_LOG'(1);
                anim_step_reg <= (anim_cnt_reg == '0);
                d_off_reg     <= d_offset;
            end

            // A request seen in the SPAWN cycle itself is held for the next frame
            if (spawn_req) begin
                pend_type_reg <= spawn_type;
                pend_vpos_reg <= spawn_vpos;
            end
            if (state_reg == ST_SPAWN) begin
                pending_reg <= spawn_req;
            end else if (spawn_req) begin
                pending_reg <= 1'b1;
            end

            for (int i = 0; i < NUM_OBJ; i++) begin
                if (state_reg == ST_IDLE && frame_evt) begin
                    shadow_reg[i]        <= obj_reg[i];
                    shadow_active_reg[i] <= active_reg[i];
                end else if (state_reg == ST_UPDATE && slot_reg == SLOT_W'(i)) begin
                    shadow_reg[i]        <= upd_desc[i];
                    shadow_active_reg[i] <= upd_active[i];
                end else if (spawn_ack && free_slot == SLOT_W'(i)) begin
                    shadow_reg[i]        <= {3'd0, pend_type_reg, SPAWN_HPOS, pend_vpos_reg};
                    shadow_active_reg[i] <= 1'b1;
                end
            end

            if (state_reg == ST_COMMIT) begin
                active_reg <= shadow_active_reg;
                for (int i = 0; i < NUM_OBJ; i++) begin
                    obj_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    assign obj1   = obj_reg[0];
    assign obj2   = obj_reg[1];
    assign obj3   = obj_reg[2];
    assign obj4   = obj_reg[3];
    assign obj5   = obj_reg[4];
    assign active = active_reg;

endmodule

// File: doc/object_scheduler.md
Name: object_scheduler

Overview:
Per-frame controller for the on-screen object descriptors fed to the display block (obj1..obj5).
- Once per VGA frame (vsync falling edge) it scrolls every active object left by the frame's d_offset and despawns objects that leave the screen.
- Every ANIM_DIV frames it advances each active object's animation frame.
- It services one spawn request per frame into the lowest free slot.
- Descriptor tables are committed atomically so the display never sees a half-updated set.

Parameters:
NUM_OBJ, 5, number of object slots (fixed 5 for port list; logic indexed generically)
ANIM_DIV_LOG, 3, animation advances once every 2^ANIM_DIV_LOG frames
SCREEN_WIDTH, 1024, spawn horizontal position is SCREEN_WIDTH-1

Ports:
clock  in  1  65 MHz pixel clock
reset  in  1  synchronous, active-low reset
vsync  in  1  xvga vsync, active-high, synchronous to clock
d_offset  in  11  horizontal scroll per frame, unsigned
spawn_req  in  1  spawn request, level sampled each cycle
spawn_type  in  2  object type for spawn, sampled with spawn_req
spawn_vpos  in  10  object vertical position for spawn, sampled with spawn_req
spawn_ack  out  1  1-cycle pulse: request placed in a slot
spawn_drop  out  1  1-cycle pulse: request discarded, no free slot
obj1..obj5  out  26  descriptor {frame[25:23], type[22:21], hpos[20:10], vpos[9:0]}
active  out  5  bit i set = slot i+1 occupied
busy  out  1  high while the update sequence runs

Behaviour:
- Reset (reset=0 at a clock edge):
  - obj1..obj5, active, spawn_ack, spawn_drop, busy and anim counter = 0.
  - Pending-spawn flag cleared; FSM to IDLE.
  - Overrides any in-progress sequence; no commit occurs.
- Edge detect: prev_vsync registered each cycle. Frame event = prev_vsync=1 and vsync=0 in cycle N.
- FSM: IDLE -> UPDATE -> SPAWN -> COMMIT -> IDLE.
  - IDLE -> UPDATE at N+1; busy=1 from N+1 through COMMIT.
  - UPDATE visits slot k (0..NUM_OBJ-1) at cycle N+1+k, on a shadow copy of the table.
  - SPAWN at N+1+NUM_OBJ.
  - COMMIT at N+2+NUM_OBJ: shadow copied to obj*/active. New values are visible from N+3+NUM_OBJ; busy=0 at that same cycle.
- Frame events while busy=1 are ignored (cannot occur at legal VGA timing).
- Anim counter (ANIM_DIV_LOG bits) increments at each frame event, wrapping. Animation step is taken for frames where the counter was 0 before the increment.
- UPDATE per active slot:
  - If hpos < d_offset: slot cleared (descriptor 0, active bit 0).
  - Otherwise hpos <= hpos - d_offset.
  - On an animation-step frame, frame <= frame+1 mod 8.
  - Type and vpos unchanged.
  - Inactive slots are untouched.
  - d_offset=0: positions hold; frame still advances.
- Spawn latching:
  - spawn_req=1 in any cycle sets pending and captures type/vpos. A later request overwrites captured fields while pending (last wins).
  - Requests during SPAWN/COMMIT apply to the next frame.
- SPAWN state, if pending:
  - Lowest-index slot that is inactive after UPDATE gets {0, type, SCREEN_WIDTH-1, vpos} and its active bit set; spawn_ack pulses this cycle.
  - If no slot is free, spawn_drop pulses instead.
  - Pending is cleared in both cases.
  - A slot freed by despawn in the same frame is eligible.
- Arithmetic: hpos 11-bit unsigned; no negative values are ever stored.

Optional Feature:
OBJ_WRAP_EN
- Defined: an object that would underflow (hpos < d_offset) is not cleared. hpos <= SCREEN_WIDTH-1 - (d_offset - hpos - 1); type, vpos and frame are kept.
  - That slot is never freed by scrolling, only by reset.
  - Spawn still fills only free slots.
- Undefined: despawn behaviour as above.

Test Plan:
- Reset, then spawn_req with type=2, vpos=300, plus one vsync fall → spawn_ack at N+6; obj1=={0,2,1023,300}, active=00001 at N+8; busy high N+1..N+7.
- One object at hpos 1023, d_offset=100, 3 frames → hpos 923, 823, 723; frame field increments only on frames where anim counter was 0 (once per 8 frames).
- Object at hpos 50, d_offset=51 → slot cleared, active bit 0. With OBJ_WRAP_EN: hpos=1023, still active.
- Five slots full, spawn_req → spawn_drop pulse, no descriptor change. Next, one object despawns in the same frame as a request → request fills that slot, spawn_ack.
- Two spawn_req pulses (vpos 100 then 200) before one frame → single object with vpos 200; next frame no spawn.
- reset=0 asserted at N+3 of a sequence → all outputs 0 the next cycle; no commit; the following frame runs normally.
